// File: rtl/tcp_rx_proto_calc.sv
// Receive-side TCP engine: validates ACKs and in-order payload per flow,
// writes back RX state, emits payload descriptors and scheduler commands.
module tcp_rx_proto_calc #(
  parameter int FLOWID_W = 3,
  parameter int SEQ_W    = 32,
  parameter int WIN_W    = 16,
  parameter int PTR_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hdr_val,
  output logic                hdr_rdy,
  input  logic [FLOWID_W-1:0] hdr_flowid,
  input  logic [SEQ_W-1:0]    hdr_seq,
  input  logic [SEQ_W-1:0]    hdr_ack,
  input  logic [WIN_W-1:0]    hdr_win,
  input  logic [WIN_W-1:0]    hdr_len,
  input  logic                hdr_ack_flag,
  output logic                state_rd_val,
  output logic [FLOWID_W-1:0] state_rd_addr,
  input  logic [SEQ_W-1:0]    rd_their_ack,
  input  logic [SEQ_W-1:0]    rd_our_ack,
  input  logic [WIN_W-1:0]    rd_their_win,
  input  logic [WIN_W-1:0]    rd_our_win,
  input  logic [1:0]          rd_dup_cnt,
  input  logic [SEQ_W-1:0]    rd_our_seq,
  output logic                state_wr_val,
  output logic [FLOWID_W-1:0] state_wr_addr,
  output logic [SEQ_W-1:0]    wr_their_ack,
  output logic [SEQ_W-1:0]    wr_our_ack,
  output logic [WIN_W-1:0]    wr_their_win,
  output logic [WIN_W-1:0]    wr_our_win,
  output logic [1:0]          wr_dup_cnt,
  output logic                pay_val,
  input  logic                pay_rdy,
  output logic [FLOWID_W-1:0] pay_flowid,
  output logic [PTR_W-1:0]    pay_addr,
  output logic [WIN_W-1:0]    pay_len,
  output logic                cmd_val,
  input  logic                cmd_rdy,
  output logic [FLOWID_W-1:0] cmd_flowid,
  output logic [1:0]          cmd_ack_pend,
  output logic [1:0]          cmd_data_pend,
  output logic [1:0]          cmd_rt_pend
);

  typedef enum logic [1:0] {IDLE, RD, CALC, OUT} state_e;

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] SET = 2'd1;
  localparam logic [1:0] CLR = 2'd2;

  state_e state_q, state_d;

  logic [FLOWID_W-1:0] flow_q, flow_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [SEQ_W-1:0]    ack_q, ack_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [WIN_W-1:0]    len_q, len_d;
  logic                flag_q, flag_d;

  logic [SEQ_W-1:0]    wta_q, wta_d;
  logic [SEQ_W-1:0]    woa_q, woa_d;
  logic [WIN_W-1:0]    wtw_q, wtw_d;
  logic [WIN_W-1:0]    wow_q, wow_d;
  logic [1:0]          wdc_q, wdc_d;
  logic [1:0]          ap_q, ap_d;
  logic [1:0]          dp_q, dp_d;
  logic [1:0]          rp_q, rp_d;
  logic                first_q, first_d;
  logic                cdone_q, cdone_d;
  logic                pdone_q, pdone_d;

  logic [SEQ_W-1:0] d_new, d_out;
  logic             new_ack, dup_ack, acc;
  logic             cmd_fire, pay_fire;

  // ACK classification uses modular distances from our_ack
  assign d_new   = ack_q - rd_our_ack;
  assign d_out   = rd_our_seq - rd_our_ack;
  assign new_ack = flag_q && (d_new != '0) && (d_new <= d_out);
  assign dup_ack = flag_q && (d_new == '0) && (len_q == '0)
                && (win_q == rd_their_win) && (d_out != '0);
  assign acc     = (len_q != '0) && (seq_q == rd_their_ack)
                && (len_q <= rd_our_win);

  assign hdr_rdy       = (state_q == IDLE) && !rst;
  assign state_rd_val  = (state_q == RD);
  assign state_rd_addr = flow_q;
  assign state_wr_val  = (state_q == OUT) && first_q;
  assign state_wr_addr = flow_q;
  assign wr_their_ack  = wta_q;
  assign wr_our_ack    = woa_q;
  assign wr_their_win  = wtw_q;
  assign wr_our_win    = wow_q;
  assign wr_dup_cnt    = wdc_q;
  assign pay_val       = (state_q == OUT) && !pdone_q;
  assign pay_flowid    = flow_q;
  assign pay_addr      = seq_q[PTR_W-1:0];
  assign pay_len       = len_q;
  assign cmd_val       = (state_q == OUT) && !cdone_q;
  assign cmd_flowid    = flow_q;
  assign cmd_ack_pend  = ap_q;
  assign cmd_data_pend = dp_q;
  assign cmd_rt_pend   = rp_q;
  assign cmd_fire      = cmd_val && cmd_rdy;
  assign pay_fire      = pay_val && pay_rdy;

  always_comb begin
    state_d = state_q;
    flow_d  = flow_q;
    seq_d   = seq_q;
    ack_d   = ack_q;
    win_d   = win_q;
    len_d   = len_q;
    flag_d  = flag_q;
    wta_d   = wta_q;
    woa_d   = woa_q;
    wtw_d   = wtw_q;
    wow_d   = wow_q;
    wdc_d   = wdc_q;
    ap_d    = ap_q;
    dp_d    = dp_q;
    rp_d    = rp_q;
    first_d = first_q;
    cdone_d = cdone_q;
    pdone_d = pdone_q;
    unique case (state_q)
      IDLE: begin
        if (hdr_val) begin
          flow_d  = hdr_flowid;
          seq_d   = hdr_seq;
          ack_d   = hdr_ack;
          win_d   = hdr_win;
          len_d   = hdr_len;
          flag_d  = hdr_ack_flag;
          state_d = RD;
        end
      end
      RD: state_d = CALC;
      CALC: begin
        woa_d = new_ack ? ack_q : rd_our_ack;
        if (new_ack)
          wdc_d = 2'd0;
        else if (dup_ack)
          wdc_d = (rd_dup_cnt == 2'd3) ? 2'd3 : rd_dup_cnt + 2'd1;
        else
          wdc_d = rd_dup_cnt;
        wtw_d = flag_q ? win_q : rd_their_win;
        wta_d = acc ? rd_their_ack + SEQ_W'(len_q) : rd_their_ack;
        wow_d = acc ? rd_our_win - len_q : rd_our_win;
        ap_d  = (len_q != '0) ? SET : NOP;
        dp_d  = (new_ack || (flag_q && win_q > rd_their_win)) ? SET : NOP;
        if (dup_ack && rd_dup_cnt == 2'd2)
          rp_d = SET;
        else if (new_ack && ack_q == rd_our_seq)
          rp_d = CLR;
        else
          rp_d = NOP;
        first_d = 1'b1;
        cdone_d = 1'b0;
        // no descriptor owed when data was not accepted
        pdone_d = !acc;
        state_d = OUT;
      end
      OUT: begin
        first_d = 1'b0;
        if (cmd_fire) cdone_d = 1'b1;
        if (pay_fire) pdone_d = 1'b1;
        if ((cdone_q || cmd_fire) && (pdone_q || pay_fire))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flow_q  <= '0;
      seq_q   <= '0;
      ack_q   <= '0;
      win_q   <= '0;
      len_q   <= '0;
      flag_q  <= 1'b0;
      wta_q   <= '0;
      woa_q   <= '0;
      wtw_q   <= '0;
      wow_q   <= '0;
      wdc_q   <= '0;
      ap_q    <= '0;
      dp_q    <= '0;
      rp_q    <= '0;
      first_q <= 1'b0;
      cdone_q <= 1'b0;
      pdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flow_q  <= flow_d;
      seq_q   <= seq_d;
      ack_q   <= ack_d;
      win_q   <= win_d;
      len_q   <= len_d;
      flag_q  <= flag_d;
      wta_q   <= wta_d;
      woa_q   <= woa_d;
      wtw_q   <= wtw_d;
      wow_q   <= wow_d;
      wdc_q   <= wdc_d;
      ap_q    <= ap_d;
      dp_q    <= dp_d;
      rp_q    <= rp_d;
      first_q <= first_d;
      cdone_q <= cdone_d;
      pdone_q <= pdone_d;
    end
  end

endmodule

// File: doc/tcp_rx_proto_calc.md
# tcp_rx_proto_calc

Receive-side TCP protocol engine, the counterpart of the transmit datapath. It takes parsed inbound segment headers one at a time and reads that flow's RX and TX state. It validates ACKs and in-order payload, writes the updated RX state back, emits an RX payload-buffer write descriptor for accepted data, and issues one scheduler update command per segment. The TX side consumes these commands to send ACKs, send new data or retransmit.

## Interface
- FLOWID_W, 3: flow index width
- SEQ_W, 32: sequence/ack number width
- WIN_W, 16: window and payload length width
- PTR_W, 16: RX payload buffer address width (addr = seq[PTR_W-1:0])
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- hdr_val / hdr_rdy  in / out  1 / 1  inbound segment handshake
- hdr_flowid, hdr_seq, hdr_ack, hdr_win, hdr_len  in  FLOWID_W/SEQ_W/SEQ_W/WIN_W/WIN_W  segment fields; hdr_len is payload bytes
- hdr_ack_flag  in  1  TCP ACK bit
- state_rd_val, state_rd_addr  out  1, FLOWID_W  read request to the RX-state and TX-state memories
- rd_their_ack, rd_our_ack, rd_their_win, rd_our_win, rd_dup_cnt  in  SEQ_W/SEQ_W/WIN_W/WIN_W/2  RX state, valid exactly 1 cycle after state_rd_val
- rd_our_seq  in  SEQ_W  TX next-send seq, same timing
- state_wr_val, state_wr_addr, wr_their_ack, wr_our_ack, wr_their_win, wr_our_win, wr_dup_cnt  out  RX state write, fields as read
- pay_val / pay_rdy  out / in  1 / 1  payload descriptor handshake
- pay_flowid, pay_addr, pay_len  out  FLOWID_W, PTR_W, WIN_W
- cmd_val / cmd_rdy  out / in  1 / 1  scheduler command handshake
- cmd_flowid  out  FLOWID_W
- cmd_ack_pend, cmd_data_pend, cmd_rt_pend  out  2 each; NOP=0, SET=1, CLEAR=2

## Operation
- FSM states: IDLE, RD, CALC, OUT.
  - IDLE: hdr_rdy=1. On hdr_val, register header fields and go to RD.
  - RD: state_rd_val=1 with addr = registered flowid, then go to CALC.
  - CALC: compute results, register them and go to OUT.
  - OUT: state_wr_val pulses for the first cycle only. Assert cmd_val, and pay_val if data was accepted. Each is held until its own handshake completes; per-channel done flags track completion. Return to IDLE when all required handshakes are done.
- Arithmetic is modulo 2^SEQ_W with unsigned differences. d_new = hdr_ack - rd_our_ack; d_out = rd_our_seq - rd_our_ack.
- New ACK: ack_flag && d_new != 0 && d_new <= d_out. Result: our_ack = hdr_ack, dup_cnt = 0.
- Dup ACK: ack_flag && d_new == 0 && hdr_len == 0 && hdr_win == rd_their_win && d_out != 0. Result: dup_cnt saturating-increments to 3.
- Any other ACK (stale or beyond our_seq): our_ack and dup_cnt unchanged.
- Window: if ack_flag, their_win = hdr_win; otherwise unchanged.
- Data accept: hdr_len != 0 && hdr_seq == rd_their_ack && hdr_len <= rd_our_win.
  - On accept: their_ack += hdr_len, our_win -= hdr_len, and the descriptor carries addr = hdr_seq[PTR_W-1:0], len = hdr_len.
  - Out-of-order or oversized data is dropped with no descriptor and state unchanged.
- Scheduler command fields:
  - ack_pend: SET if hdr_len != 0 (accepted or dropped, so the peer gets an ACK or dup-ACK); otherwise NOP.
  - data_pend: SET on a new ACK or when hdr_win > rd_their_win with ack_flag; otherwise NOP.
  - rt_pend: SET when dup_cnt moves 2→3. CLEAR on a new ACK with hdr_ack == rd_our_seq. Otherwise NOP.
- A command is always issued, even when all fields are NOP.

## Timing
- Reset values: hdr_rdy=0 during reset, then 1 in IDLE. All *_val=0. All datapath registers 0. FSM goes to IDLE asynchronously.
- Reset mid-operation abandons the segment. No write or handshake completes after rst rises.
- Minimum latency from the header accept edge (cycle 0): RD in cycle 1, CALC in cycle 2, OUT in cycle 3 (wr pulse, cmd_val/pay_val). Back in IDLE at cycle 4 if both ready signals are high. Throughput is one segment per 4 cycles.
- Outputs are stable while val=1 and rdy=0. val never drops before the handshake completes.
- When cmd and pay complete in different cycles, each val drops after its own handshake.
- rd_* data is sampled only in CALC. Back-to-back segments of the same flow see the prior write, because the write precedes the next RD.

## Test plan
- In-order data, flow 2: state their_ack=1000, our_win=4096; hdr seq=1000, len=200, ack_flag=0 -> wr_their_ack=1200, wr_our_win=3896, pay addr=1000 len=200, cmd ack_pend=SET data_pend=NOP rt_pend=NOP.
- Out-of-order data: hdr seq=1500 with their_ack=1000 -> no pay_val, state unchanged, ack_pend=SET.
- Full ACK: our_ack=5000, our_seq=6000; hdr ack=6000, win=8000, ack_flag=1 -> wr_our_ack=6000, dup_cnt=0, data_pend=SET, rt_pend=CLEAR.
- Three dup ACKs at ack=5000 with our_seq=6000 and unchanged window -> dup_cnt 1,2,3; rt_pend=SET on the third only. A fourth dup ACK gives dup_cnt=3, rt_pend=NOP.
- Wrap-around: our_ack=0xFFFF_FF00, our_seq=0x0000_0100; hdr ack=0x0000_0010 -> accepted as new ACK. hdr ack=0x0000_0200 -> rejected, state unchanged.
- Backpressure and reset: hold cmd_rdy=0 for 5 cycles with pay_rdy=1 -> pay completes, cmd_val held stable, hdr_rdy=0 until cmd completes. Assert rst mid-OUT -> all val=0 immediately, IDLE after release.
